// File: rtl/mult_div_unit.sv
// mult_div_unit: E-stage multiply/divide unit that owns the HI/LO registers.
// It runs mult/multu/div/divu for a fixed latency, serves mfhi/mflo and
// mthi/mtlo, and reports busy to the stall unit.
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   MDUOp    E-stage op: 0 none,1 mult,2 multu,3 div,4 divu,5 mfhi,6 mflo,7 mthi,8 mtlo
//   start    one-cycle launch pulse for ops 1..4
//   A, B     forwarded rs / rt operands
//   MDUBusy  start | busy (combinational)
//   MDUOut   HI for mfhi, LO for mflo, else 0 (combinational)
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        MDUBusy,
  output logic [31:0] MDUOut
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_hi_p;
  logic [31:0]      r_lo_p;
  logic             r_commit;

  logic        w_busy;
  logic        w_accept;
  logic        w_is_mul;
  logic        w_is_div;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_abs_a;
  logic [31:0] w_abs_b;
  logic [31:0] w_dvsr_s;
  logic [31:0] w_dvsr_u;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;
  logic        w_res_ok;

  assign w_busy   = (r_state == S_RUN);
  assign w_accept = start && !w_busy;
  assign w_is_mul = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU);
  assign w_is_div = (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU);

  // Low 64 bits of a 64x64 product equal the 32x32 product of the extended operands.
  assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_prod_u = {32'd0, A} * {32'd0, B};

  // Signed divide on magnitudes, then restore signs (quotient truncates toward zero,
  // remainder follows the dividend). Zero divisors are steered to 1 to keep the
  // datapath defined; such results are never committed.
  assign w_abs_a  = A[31] ? (~A + 32'd1) : A;
  assign w_abs_b  = B[31] ? (~B + 32'd1) : B;
  assign w_dvsr_s = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_dvsr_u = (B == 32'd0) ? 32'd1 : B;
  assign w_q_mag  = w_abs_a / w_dvsr_s;
  assign w_r_mag  = w_abs_a % w_dvsr_s;
  assign w_q_s    = (A[31] ^ B[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
  assign w_r_s    = A[31] ? (~w_r_mag + 32'd1) : w_r_mag;

  // Result selection for the op being launched.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    w_res_ok = 1'b0;
    case (MDUOp)
      OP_MULT:  begin {w_res_hi, w_res_lo} = w_prod_s; w_res_ok = 1'b1; end
      OP_MULTU: begin {w_res_hi, w_res_lo} = w_prod_u; w_res_ok = 1'b1; end
      OP_DIV:   begin w_res_hi = w_r_s; w_res_lo = w_q_s; w_res_ok = (B != 32'd0); end
      OP_DIVU:  begin w_res_hi = A % w_dvsr_u; w_res_lo = A / w_dvsr_u; w_res_ok = (B != 32'd0); end
      default:  ;
    endcase
  end

  // Control FSM, pending result and HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_hi_p   <= 32'd0;
      r_lo_p   <= 32'd0;
      r_commit <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            // Start wins over an mt in the same cycle.
            r_state  <= S_RUN;
            r_cnt    <= w_is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            r_hi_p   <= w_res_hi;
            r_lo_p   <= w_res_lo;
            r_commit <= w_res_ok && (w_is_mul || w_is_div);
          end else if (MDUOp == OP_MTHI) begin
            r_hi <= A;
          end else if (MDUOp == OP_MTLO) begin
            r_lo <= A;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_IDLE;
            if (r_commit) begin
              r_hi <= r_hi_p;
              r_lo <= r_lo_p;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign MDUBusy = start | w_busy;

  // Reads see registered HI/LO only; no bypass of an in-flight result.
  always_comb begin
    MDUOut = 32'd0;
    if (MDUOp == OP_MFHI)      MDUOut = r_hi;
    else if (MDUOp == OP_MFLO) MDUOut = r_lo;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: table of spec vectors, hand sequences for
// reset/abort/collision cases, and random traffic against a cycle-indexed model.
module tb_mult_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  MDUOp;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        MDUBusy;
  logic [31:0] MDUOut;

  mult_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .MDUOp(MDUOp), .start(start),
    .A(A), .B(B), .MDUBusy(MDUBusy), .MDUOut(MDUOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: HI/LO plus the cycle on which the running op commits.
  int          cyc = 0;
  int          m_end = -1;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [31:0] m_phi = 32'd0, m_plo = 32'd0;
  logic        m_pvalid = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  function automatic int lat(input logic [3:0] op);
    return (op == 4'd1 || op == 4'd2) ? int'(MULT_N) : int'(DIV_N);
  endfunction

  // Compute the architectural result of an op with plain 64-bit arithmetic.
  task automatic compute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic ok);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0; lo = 32'd0; ok = 1'b0;
    case (op)
      4'd1: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; ok = 1'b1; end
      4'd2: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; ok = 1'b1; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; ok = 1'b1; end
      4'd4: if (b != 0) begin hi = a % b; lo = a / b; ok = 1'b1; end
      default: ;
    endcase
  endtask

  // Advance the model across the clock edge that ends the current cycle.
  task automatic model_edge(input logic [3:0] op, input logic st, input logic [31:0] a,
                            input logic [31:0] b, input logic rst);
    if (!rst) begin
      m_hi = 0; m_lo = 0; m_end = -1; m_pvalid = 1'b0;
    end else if (cyc <= m_end) begin
      if (cyc == m_end && m_pvalid) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (st) begin
      compute(op, a, b, m_phi, m_plo, m_pvalid);
      m_end = cyc + lat(op);
    end else if (op == 4'd7) m_hi = a;
    else if (op == 4'd8) m_lo = a;
    cyc++;
  endtask

  // One cycle: drive, check combinational outputs against the model, cross the edge.
  task automatic do_cycle(input logic [3:0] op, input logic st, input logic [31:0] a,
                          input logic [31:0] b, input logic rst,
                          output logic busy_o, output logic [31:0] out_o);
    logic        e_busy;
    logic [31:0] e_out;
    MDUOp = op; start = st; A = a; B = b; reset = rst;
    #1;
    e_busy = st | (rst && (cyc <= m_end));
    e_out  = !rst ? 32'd0 : (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
    busy_o = MDUBusy;
    out_o  = MDUOut;
    check("model_busy", {31'd0, busy_o}, {31'd0, e_busy});
    check("model_out", out_o, e_out);
    @(posedge clk);
    model_edge(op, st, a, b, rst);
    #1;
  endtask

  // Launch an op and count MDUBusy-high cycles (start cycle included), reading LO meanwhile.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cnt, output logic [31:0] lo_after);
    logic        bz;
    logic [31:0] o;
    int          k;
    do_cycle(op, 1'b1, a, b, 1'b1, bz, o);
    busy_cnt = bz ? 1 : 0;
    lo_after = 32'd0;
    for (k = 0; k < 40; k++) begin
      do_cycle(4'd6, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
      if (!bz) begin lo_after = o; break; end
      busy_cnt++;
    end
    if (k == 40) begin
      failures++;
      $display("FAIL busy_timeout got=busy expected=idle within 40 cycles");
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic        bz;
    logic [31:0] o;
    logic [31:0] lo_r;
    int          n;
    logic [3:0]  op;
    logic        st;
    logic [31:0] ra, rb;

    vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[1] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{4'd4, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
    vecs[4] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{4'd1, 32'd7,        32'd6,        32'h00000000, 32'h0000002A};
    vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};

    MDUOp = 4'd0; start = 1'b0; A = 32'd0; B = 32'd0; reset = 1'b0;
    #1;

    // Reset state: outputs zero, busy follows start while reset is held.
    do_cycle(4'd5, 1'b0, 32'd0, 32'd0, 1'b0, bz, o);
    check("rst_mfhi", o, 32'd0);
    do_cycle(4'd1, 1'b1, 32'd3, 32'd3, 1'b0, bz, o);
    check("rst_busy_eq_start", {31'd0, bz}, 32'd1);
    do_cycle(4'd6, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    check("rst_mflo", o, 32'd0);

    // Spec vectors.
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n, lo_r);
      check($sformatf("vec%0d_busy_cycles", i), 32'(n), 32'(lat(vecs[i].op) + 1));
      check($sformatf("vec%0d_lo_next", i), lo_r, vecs[i].lo);
      do_cycle(4'd5, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
      check($sformatf("vec%0d_hi", i), o, vecs[i].hi);
    end

    // mthi then divu by zero: HI kept, LO kept, full busy period.
    do_cycle(4'd7, 1'b0, 32'h12345678, 32'd0, 1'b1, bz, o);
    run_op(4'd4, 32'd99, 32'd0, n, lo_r);
    check("dz_busy_cycles", 32'(n), 32'(DIV_N + 1));
    check("dz_lo_kept", lo_r, 32'hFFFFFFFD);
    do_cycle(4'd5, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    check("dz_hi_kept", o, 32'h12345678);

    // Reset in the 4th busy cycle of a div aborts it.
    do_cycle(4'd3, 1'b1, 32'd100, 32'd3, 1'b1, bz, o);
    do_cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    do_cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    do_cycle(4'd5, 1'b0, 32'd0, 32'd0, 1'b0, bz, o);
    check("abort_busy", {31'd0, bz}, 32'd0);
    check("abort_hi", o, 32'd0);
    for (int i = 0; i < 12; i++) begin
      do_cycle(4'd6, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
      check("abort_lo_stays0", o, 32'd0);
    end

    // mult in flight: restart and mthi ignored, original product commits on time.
    do_cycle(4'd1, 1'b1, 32'd3, 32'd4, 1'b1, bz, o);
    do_cycle(4'd1, 1'b1, 32'd9, 32'd9, 1'b1, bz, o);
    do_cycle(4'd7, 1'b0, 32'hDEAD, 32'd0, 1'b1, bz, o);
    do_cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    do_cycle(4'd0, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    do_cycle(4'd8, 1'b0, 32'hBEEF, 32'd0, 1'b1, bz, o);  // commit cycle: mtlo dropped
    check("inflight_busy_last", {31'd0, bz}, 32'd1);
    do_cycle(4'd6, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    check("inflight_busy_done", {31'd0, bz}, 32'd0);
    check("inflight_lo", o, 32'd12);
    do_cycle(4'd5, 1'b0, 32'd0, 32'd0, 1'b1, bz, o);
    check("inflight_hi", o, 32'd0);

    // Random traffic; start mostly only when idle, occasionally while busy.
    for (int i = 0; i < 600; i++) begin
      op = 4'($urandom_range(0, 8));
      st = 1'b0;
      if (op >= 4'd1 && op <= 4'd4)
        st = ((cyc > m_end) || ($urandom_range(0, 7) == 0)) && ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 3))
        0: ra = 32'h80000000;
        1: ra = 32'($urandom_range(0, 20));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      do_cycle(op, st, ra, rb, 1'b1, bz, o);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
